// File: rtl/mfcc_vq_fifo_wr_arb.sv
// Round-robin, frame-granular write arbiter feeding N_REQ requesters into a single FIFO write port.
// Optional stall watchdog: define MFCC_VQ_ARB_TIMEOUT_EN to abort frames that stall for TIMEOUT cycles.
module mfcc_vq_fifo_wr_arb #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned FRAME_LEN = 13,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    output logic [DATA_W-1:0]         fifo_wr_data,
    output logic                      fifo_wr_en,
    input  logic                      fifo_wr_vld,
    output logic [N_REQ-1:0]          grant,
    output logic                      frame_done,
    output logic                      timeout_err
);

    localparam int unsigned OWN_W = $clog2(N_REQ);
    localparam int unsigned CNT_W = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(FRAME_LEN - 1);
    localparam logic [OWN_W-1:0] LAST_REQ  = OWN_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0  = N_REQ'(1);

    // Elaboration-time parameter range checks
    if (N_REQ < 2 || N_REQ > 8) begin : g_chk_n_req
        $error("mfcc_vq_fifo_wr_arb: N_REQ must be in 2..8");
    end
    if (FRAME_LEN < 2 || FRAME_LEN > 255) begin : g_chk_frame_len
        $error("mfcc_vq_fifo_wr_arb: FRAME_LEN must be in 2..255");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_chk_timeout
        $error("mfcc_vq_fifo_wr_arb: TIMEOUT must be in 1..65535");
    end

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [OWN_W-1:0]   owner;
    logic [OWN_W-1:0]   last_owner;
    logic [OWN_W-1:0]   pick;
    logic [OWN_W-1:0]   cand;
    logic               pick_vld;
    logic [CNT_W-1:0]   word_cnt;
    logic               beat;
    logic               frame_end;
    logic               abort;

    assign beat      = (state == XFER) && req_valid[owner] && fifo_wr_vld;
    assign frame_end = beat && (word_cnt == LAST_WORD);

    // Round-robin search starting at last_owner+1; descending loop lets the nearest candidate win
    always_comb begin
        pick     = last_owner;
        pick_vld = 1'b0;
        cand     = last_owner;
        for (int unsigned k = N_REQ; k >= 1; k--) begin
            cand = OWN_W'((32'(last_owner) + k) % N_REQ);
            if (req_valid[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

`ifdef MFCC_VQ_ARB_TIMEOUT_EN
    logic [15:0] stall_cnt;

    assign abort = (state == XFER) && !beat && (stall_cnt == 16'(TIMEOUT - 1));

    // Consecutive no-beat cycles of the current owner
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= abort;
            if (state != XFER || beat || abort) begin
                stall_cnt <= '0;
            end else begin
                stall_cnt <= stall_cnt + 16'(1);
            end
        end
    end
`else
    assign abort       = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (pick_vld) state_nxt = XFER;
            XFER: if (frame_end || abort) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Owner's path to the FIFO; everything is gated off outside XFER
    always_comb begin
        req_ready    = '0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = '0;
        if (state == XFER) begin
            req_ready[owner] = fifo_wr_vld;
            fifo_wr_en       = req_valid[owner];
            fifo_wr_data     = req_data[32'(owner) * DATA_W +: DATA_W];
        end
    end

    // Grant, owner bookkeeping, word counter and completion pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant      <= '0;
            owner      <= '0;
            last_owner <= LAST_REQ;
            word_cnt   <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end;
            if (state == IDLE) begin
                if (pick_vld) begin
                    grant <= ONE_HOT0 << pick;
                    owner <= pick;
                end
            end else if (frame_end || abort) begin
                grant      <= '0;
                last_owner <= owner;
                word_cnt   <= '0;
            end else if (beat) begin
                word_cnt <= word_cnt + CNT_W'(1);
            end
        end
    end

endmodule
